imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 138 +++++++++++++
 tb/tb_imm_decode_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// RV32I immediate decode stage: combinational decode of the incoming word, registered into a
// 2-entry skid buffer so in_ready never depends combinationally on out_ready.
module imm_decode_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] imm_I,
   output logic [31:0] imm_I_shamt,
   output logic [31:0] imm_S,
   output logic [31:0] imm_B,
   output logic [31:0] imm_U,
   output logic [31:0] imm_J,
   output logic [2:0]  imm_SEL,
   output logic        illegal
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   typedef struct packed {
      logic [31:0] imm_i;
      logic [31:0] imm_sh;
      logic [31:0] imm_s;
      logic [31:0] imm_b;
      logic [31:0] imm_u;
      logic [31:0] imm_j;
      logic [2:0]  sel;
      logic        ill;
   } entry_t;

   state_e state_q, state_d;
   entry_t main_q, main_d, skid_q, skid_d, dec;
   logic   in_ready_q;
   logic   accept, drain;

   always_comb begin
      dec        = '0;
      dec.imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
      dec.imm_sh = {27'b0, in_inst[24:20]};
      dec.imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      dec.imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      dec.imm_u  = {in_inst[31:12], 12'b0};
      dec.imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21],
                    1'b0};
      case (in_inst[6:0])
         7'b0000011, 7'b1100111: dec.sel = 3'd0;
         7'b0010011: dec.sel = (in_inst[13:12] == 2'b01) ? 3'd5 : 3'd0; // slli/srli/srai
         7'b0100011: dec.sel = 3'd1;
         7'b1100011: dec.sel = 3'd2;
         7'b0110111, 7'b0010111: dec.sel = 3'd3;
         7'b1101111: dec.sel = 3'd4;
         default: begin
            dec.sel = 3'd7;
            dec.ill = 1'b1;
         end
      endcase
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != StEmpty);
   assign accept    = in_valid & in_ready_q & ~flush;
   assign drain     = out_valid & out_ready & ~flush;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d = StOne;
                  main_d  = dec;
               end
            end
            StOne: begin
               if (accept && drain) begin
                  main_d = dec;
               end else if (accept) begin
                  state_d = StFull;
                  skid_d  = dec;
               end else if (drain) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (drain) begin
                  state_d = StOne;
                  main_d  = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         in_ready_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != StFull);
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

   always_comb begin
      imm_I       = '0;
      imm_I_shamt = '0;
      imm_S       = '0;
      imm_B       = '0;
      imm_U       = '0;
      imm_J       = '0;
      imm_SEL     = 3'd7;
      illegal     = 1'b0;
      if (out_valid) begin
         imm_I       = main_q.imm_i;
         imm_I_shamt = main_q.imm_sh;
         imm_S       = main_q.imm_s;
         imm_B       = main_q.imm_b;
         imm_U       = main_q.imm_u;
         imm_J       = main_q.imm_j;
         imm_SEL     = main_q.sel;
         illegal     = main_q.ill;
      end
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Randomized bench for imm_decode_stage: a FIFO-occupancy reference model plus arithmetic
// immediate decode, with literal expectations for the hand-worked instruction cases.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [31:0] in_inst, imm_I, imm_I_shamt, imm_S, imm_B, imm_U, imm_J;
   logic [2:0]  imm_SEL;

   imm_decode_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .imm_I(imm_I),
      .imm_I_shamt(imm_I_shamt), .imm_S(imm_S), .imm_B(imm_B), .imm_U(imm_U), .imm_J(imm_J),
      .imm_SEL(imm_SEL), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] i, sh, s, b, u, j;
      logic [2:0]  sel;
      logic        ill;
   } exp_t;

   logic [31:0] q[$];
   logic        m_ready;
   int          n_vec = 0;
   int          n_err = 0;

   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      int   sgn;
      sgn   = w[31] ? 1 : 0;
      e.i   = 32'(-2048 * sgn + int'(w[30:20]));
      e.s   = 32'(-2048 * sgn + int'(w[30:25]) * 32 + int'(w[11:7]));
      e.b   = 32'(-4096 * sgn + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      e.j   = 32'(-1048576 * sgn + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                  + int'(w[30:21]) * 2);
      e.u   = w & 32'hFFFF_F000;
      e.sh  = (w >> 20) & 32'd31;
      e.ill = 1'b0;
      if (w[6:0] == 7'h03 || w[6:0] == 7'h67) e.sel = 3'd0;
      else if (w[6:0] == 7'h13) e.sel = (w[14:12] == 3'd1 || w[14:12] == 3'd5) ? 3'd5 : 3'd0;
      else if (w[6:0] == 7'h23) e.sel = 3'd1;
      else if (w[6:0] == 7'h63) e.sel = 3'd2;
      else if (w[6:0] == 7'h37 || w[6:0] == 7'h17) e.sel = 3'd3;
      else if (w[6:0] == 7'h6F) e.sel = 3'd4;
      else begin
         e.sel = 3'd7;
         e.ill = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all();
      exp_t e;
      logic ev;
      ev = (q.size() > 0);
      if (ev) e = model(q[0]);
      else begin
         e     = '0;
         e.sel = 3'd7;
      end
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
      chk("imm_I", imm_I, e.i);
      chk("imm_I_shamt", imm_I_shamt, e.sh);
      chk("imm_S", imm_S, e.s);
      chk("imm_B", imm_B, e.b);
      chk("imm_U", imm_U, e.u);
      chk("imm_J", imm_J, e.j);
      chk("imm_SEL", {29'b0, imm_SEL}, {29'b0, e.sel});
      chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic cycle(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
      logic acc, drn;
      in_valid  = v;
      in_inst   = w;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      acc = v && m_ready && !fl;
      drn = (q.size() > 0) && ordy && !fl;
      if (fl) q.delete();
      else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(w);
      end
      m_ready = (q.size() < 2);
      #1;
      chk_all();
   endtask

   logic [6:0]  ops[10] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h33};
   logic [31:0] rnd;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0;
      m_ready = 1'b0;
      #1;
      chk_all();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First edge after reset: in_ready still low, nothing accepted.
      cycle(1'b1, 32'hFFF0_0093, 1'b1, 1'b0);
      chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
      cycle(1'b1, 32'hFFF0_0093, 1'b1, 1'b0);
      chk("addi_valid", {31'b0, out_valid}, 32'd1);
      chk("addi_sel", {29'b0, imm_SEL}, 32'd0);
      chk("addi_imm_I", imm_I, 32'hFFFF_FFFF);
      chk("addi_illegal", {31'b0, illegal}, 32'd0);
      cycle(1'b1, 32'h0050_9093, 1'b1, 1'b0);
      chk("slli_sel", {29'b0, imm_SEL}, 32'd5);
      chk("slli_shamt", imm_I_shamt, 32'h0000_0005);
      cycle(1'b1, 32'hFFDF_F06F, 1'b1, 1'b0);
      chk("jal_sel", {29'b0, imm_SEL}, 32'd4);
      chk("jal_imm_J", imm_J, 32'hFFFF_FFFC);
      cycle(1'b1, 32'h0000_007F, 1'b1, 1'b0);
      chk("bad_sel", {29'b0, imm_SEL}, 32'd7);
      chk("bad_illegal", {31'b0, illegal}, 32'd1);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Back-pressure: three back-to-back valids with out_ready low.
      cycle(1'b1, 32'h0010_0093, 1'b0, 1'b0);
      cycle(1'b1, 32'h0020_0093, 1'b0, 1'b0);
      chk("full_in_ready", {31'b0, in_ready}, 32'd0);
      cycle(1'b1, 32'h0030_0093, 1'b0, 1'b0);
      chk("full_hold_I", imm_I, 32'd1);
      cycle(1'b1, 32'h0030_0093, 1'b1, 1'b0);
      chk("order_2nd", imm_I, 32'd2);
      cycle(1'b1, 32'h0030_0093, 1'b1, 1'b0);
      chk("order_3rd", imm_I, 32'd3);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drained", {31'b0, out_valid}, 32'd0);

      // Asynchronous reset in FULL.
      cycle(1'b1, 32'h0040_0023, 1'b0, 1'b0);
      cycle(1'b1, 32'h0050_0063, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      q.delete();
      m_ready = 1'b0;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk_all();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 32'h0, 1'b0, 1'b0);

      // Flush in FULL.
      cycle(1'b1, 32'h1234_5037, 1'b0, 1'b0);
      cycle(1'b1, 32'h8765_4017, 1'b0, 1'b0);
      cycle(1'b1, 32'hABCD_E06F, 1'b1, 1'b1);
      chk("flush_empty", {31'b0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'b0, in_ready}, 32'd1);

      for (int k = 0; k < 400; k++) begin
         rnd = $urandom();
         rnd[6:0] = ops[$urandom_range(0, 9)];
         cycle(1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 24) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
